// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states and op classifiers.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

    function automatic logic is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_mul_class(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Iterative restoring divider on unsigned magnitudes; retires DIV_BITS_PER_CYCLE quotient bits per clock.
module div_iter #(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_last,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);
    localparam int ITERS = XLEN / DIV_BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;

    // The dividend shifts out of the top of r_quo while quotient bits shift in at the bottom.
    // A set remainder MSB means the shifted value already exceeds any XLEN-bit divisor.
    always_comb begin
        logic [XLEN-1:0] v_shift;
        logic            v_ge;
        w_rem_next = r_rem;
        w_quo_next = r_quo;
        v_shift    = '0;
        v_ge       = 1'b0;
        for (int k = 0; k < DIV_BITS_PER_CYCLE; k++) begin
            v_shift    = {w_rem_next[XLEN-2:0], w_quo_next[XLEN-1]};
            v_ge       = w_rem_next[XLEN-1] | (v_shift >= r_div);
            w_rem_next = v_ge ? (v_shift - r_div) : v_shift;
            w_quo_next = {w_quo_next[XLEN-2:0], v_ge};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_start) begin
            r_cnt <= CW'(ITERS);
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end

    assign o_busy      = (r_cnt != '0);
    assign o_last      = (r_cnt == CW'(1));
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; one op at a time via valid/ready, cancellable by flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_STAGES         = 2,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  muldiv_op_e      req_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    muldiv_state_e     r_state, w_state_next;
    muldiv_op_e        r_op;
    logic [XLEN-1:0]   r_hi, r_lo, r_dividend;
    logic [CW-1:0]     r_mul_cnt;
    logic              r_done, r_neg_q, r_neg_r, r_div_zero;
    logic              w_accept, w_wr_mul, w_wr_div, w_sgn;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod, w_prod_final, w_mul_result;
    logic [XLEN-1:0]   w_abs1, w_abs2, w_quo, w_rem, w_hi_div, w_lo_div;
    logic              w_div_busy, w_div_last;

    assign req_ready = (r_state == ST_IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;
    assign w_sgn     = is_signed(req_op);

    // Sign-extending to 2*XLEN lets a single unsigned multiply serve both signednesses.
    assign w_ma   = {{XLEN{w_sgn & src1[XLEN-1]}}, src1};
    assign w_mb   = {{XLEN{w_sgn & src2[XLEN-1]}}, src2};
    assign w_prod = w_ma * w_mb;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
            logic [2*XLEN-1:0] r_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)                               r_q <= '0;
                    else if (w_accept && is_mul_class(req_op)) r_q <= w_prod;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) r_q <= '0;
                    else       r_q <= g_stage[gi-1].r_q;
                end
            end
        end
    endgenerate

    assign w_prod_final = g_stage[MUL_STAGES-1].r_q;

    always_comb begin
        w_mul_result = w_prod_final;
        case (r_op)
            OP_MADD, OP_MADDU: w_mul_result = {r_hi, r_lo} + w_prod_final;
            OP_MSUB, OP_MSUBU: w_mul_result = {r_hi, r_lo} - w_prod_final;
            default:           w_mul_result = w_prod_final;
        endcase
    end

    assign w_abs1 = (w_sgn && src1[XLEN-1]) ? -src1 : src1;
    assign w_abs2 = (w_sgn && src2[XLEN-1]) ? -src2 : src2;

    div_iter #(
        .XLEN               (XLEN),
        .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
    ) u_div_iter (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_accept && is_div(req_op)),
        .i_dividend  (w_abs1),
        .i_divisor   (w_abs2),
        .o_busy      (w_div_busy),
        .o_last      (w_div_last),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Most-negative / -1 needs no special case: the magnitude quotient already wraps to most-negative.
    assign w_lo_div = r_div_zero ? '1 : (r_neg_q ? -w_quo : w_quo);
    assign w_hi_div = r_div_zero ? r_dividend : (r_neg_r ? -w_rem : w_rem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_mul     = 1'b0;
        w_wr_div     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && is_mul_class(req_op)) w_state_next = ST_MUL;
                else if (w_accept && is_div(req_op))  w_state_next = ST_DIV;
            end
            ST_MUL: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_mul_cnt == CW'(MUL_STAGES - 1)) begin
                    w_wr_mul     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush)                         w_state_next = ST_IDLE;
                else if (w_div_busy && w_div_last) w_state_next = ST_FIX;
            end
            ST_FIX: begin
                w_wr_div     = !flush;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_op       <= OP_NOP;
            r_mul_cnt  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
        end else begin
            r_done <= w_wr_mul | w_wr_div;
            if (w_accept) begin
                r_op       <= req_op;
                r_mul_cnt  <= '0;
                r_neg_q    <= w_sgn & (src1[XLEN-1] ^ src2[XLEN-1]);
                r_neg_r    <= w_sgn & src1[XLEN-1];
                r_div_zero <= (src2 == '0);
                r_dividend <= src1;
                if (req_op == OP_MTHI) r_hi <= src1;
                if (req_op == OP_MTLO) r_lo <= src1;
            end else if (r_state == ST_MUL) begin
                r_mul_cnt <= r_mul_cnt + CW'(1);
            end
            if (w_wr_mul) {r_hi, r_lo} <= w_mul_result;
            if (w_wr_div) begin
                r_hi <= w_hi_div;
                r_lo <= w_lo_div;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO and latency, a monitor checks each done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MS   = 2;
    localparam int DLAT = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    muldiv_op_e  req_op = OP_NOP;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        req_ready, busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit prev_done = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(
        .XLEN               (32),
        .MUL_STAGES         (MS),
        .DIV_BITS_PER_CYCLE (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input muldiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] eh,
                         input logic [31:0] el);
        exp_t e;
        @(negedge clk);
        check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        src1      = $urandom;
        src2      = $urandom;
        if (push) begin
            e.name = name;
            e.hi   = eh;
            e.lo   = el;
            e.acc  = cyc;
            e.lat  = (op == OP_DIV || op == OP_DIVU) ? DLAT : MS;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy=1 required=0 after 100 cycles", name);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation, including its latency.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (prev_done) begin
                failures++;
                $display("FAIL done_pulse_width done high 2 cycles required 1");
            end
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done hi=0x%08h lo=0x%08h required no done", hi, lo);
            end else begin
                e = sb.pop_front();
                checks++;
                if (hi !== e.hi || lo !== e.lo || cyc != e.acc + e.lat) begin
                    failures++;
                    $display("FAIL %s hi=0x%08h lo=0x%08h lat=%0d required hi=0x%08h lo=0x%08h lat=%0d",
                             e.name, hi, lo, cyc - e.acc, e.hi, e.lo, e.lat);
                end else begin
                    $display("txn %s hi=0x%08h lo=0x%08h lat=%0d ok", e.name, hi, lo, cyc - e.acc);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        int ready_hi;
        int busy_lo;

        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;

        // -7 / 2 with ready/busy watched for the full latency
        issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        ready_hi = 0;
        busy_lo  = 0;
        repeat (DLAT) begin
            @(negedge clk);
            if (req_ready) ready_hi++;
            if (!busy) busy_lo++;
        end
        check("div_ready_low_cycles", ready_hi, 32'd0);
        check("div_busy_low_cycles", busy_lo, 32'd0);
        wait_idle("div_m7_2");

        issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        wait_idle("multu_max");

        issue("mthi_0", OP_MTHI, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("mthi_0_hi", hi, 32'h0);
        issue("mtlo_5", OP_MTLO, 32'd5, 32'h0, 1'b0, 32'h0, 32'h0);
        check("mtlo_5_lo", lo, 32'd5);

        issue("madd_3_m2", OP_MADD, 32'd3, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("madd_3_m2");
        issue("msubu_1_1", OP_MSUBU, 32'd1, 32'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_idle("msubu_1_1");
        issue("mult_m3_7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
        wait_idle("mult_m3_7");
        issue("msub_m1_2", OP_MSUB, 32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFED);
        wait_idle("msub_m1_2");
        issue("maddu_max_2", OP_MADDU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h00000001, 32'hFFFFFFEB);
        wait_idle("maddu_max_2");

        issue("divu_by0", OP_DIVU, 32'h1234, 32'h0, 1'b1, 32'h00001234, 32'hFFFFFFFF);
        wait_idle("divu_by0");
        issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000);
        wait_idle("div_ovf");
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        wait_idle("divu_100_7");
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD);
        wait_idle("div_7_m2");
        issue("div_m7_by0", OP_DIV, 32'hFFFFFFF9, 32'h0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF);
        wait_idle("div_m7_by0");

        // flush in the tenth cycle of a divide
        issue("mthi_aa", OP_MTHI, 32'hAA, 32'h0, 1'b0, 32'h0, 32'h0);
        check("mthi_aa_hi", hi, 32'hAA);
        issue("div_flushed", OP_DIV, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'b0, req_ready}, 32'd1);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'hFFFFFFFF);

        // request coinciding with flush is ignored
        req_valid = 1'b1;
        req_op    = OP_MTLO;
        src1      = 32'h55;
        flush     = 1'b1;
        #1;
        check("reqflush_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        flush     = 1'b0;
        @(negedge clk);
        check("reqflush_lo", lo, 32'hFFFFFFFF);
        check("reqflush_busy", {31'b0, busy}, 32'd0);

        // flush on the final multiply write edge
        issue("mult_flushed", OP_MULT, 32'd2, 32'd3, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("mflush_busy", {31'b0, busy}, 32'd0);
        check("mflush_hi", hi, 32'hAA);
        check("mflush_lo", lo, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);

        // asynchronous reset in the middle of a divide
        issue("div_reset", OP_DIV, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0);
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ready", {31'b0, req_ready}, 32'd1);
        check("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue("mult_after_rst", OP_MULT, 32'd5, 32'd6, 1'b1, 32'h0, 32'd30);
        wait_idle("mult_after_rst");
        repeat (3) @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
